// File: rtl/frequency_uart_reporter.sv
// Formats each captured BCD result as an ASCII line (digits, optional '.', CR, LF) into a byte UART; first write 2 cycles after strobe.
// Holds off while uart_busy is high; one-deep pending buffer keeps the newest result, counting discarded ones.
module frequency_uart_reporter #(
    parameter int NUMBER_OF_DIGITS       = 8,
    parameter int BLANK_LEADING_ZEROS    = 1,
    parameter int DECIMAL_POINT_POSITION = 0
) (
    input  logic                          clock,
    input  logic                          resetb,
    input  logic [4*NUMBER_OF_DIGITS-1:0] bcd_in,
    input  logic                          bcd_valid,
    input  logic                          uart_busy,
    output logic                          uart_wr,
    output logic [7:0]                    uart_dat,
    output logic                          line_active,
    output logic [7:0]                    overrun_count
);

    localparam int N           = NUMBER_OF_DIGITS;
    localparam int DP          = DECIMAL_POINT_POSITION;
    localparam int HAS_DP      = (DP > 0) ? 1 : 0;
    localparam int L           = N + HAS_DP + 2;
    localparam int IDXW        = $clog2(L);
    localparam int W           = 4 * N;
    localparam int BLANK_LIMIT = N - 1 - DP;

    typedef logic [IDXW-1:0] idx_t;
    localparam idx_t LAST_IDX = idx_t'(L - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_GAP,
        S_WAIT,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   line_q, line_d;
    logic [W-1:0]   pend_q, pend_d;
    logic           pend_vld_q, pend_vld_d;
    logic [7:0]     ovr_q, ovr_d;
    idx_t           idx_q, idx_d;
    logic [N-1:0]   mask_q, mask_d;
    logic [7:0]     dat_q, dat_d;

    logic [N-1:0]   blank_mask;
    logic           lead;
    logic [7:0]     cur_byte;
    logic [3:0]     nyb;
    logic           nyb_blank;
    int             pos;
    int             dig;

    // Blanking runs from the MS digit and stops at the first nonzero nybble or at the
    // digit left of the point (the LS digit when there is no point).
    always_comb begin
        blank_mask = '0;
        lead       = (BLANK_LEADING_ZEROS != 0);
        for (int i = 0; i < N; i++) begin
            if (lead && (i < BLANK_LIMIT) && (line_q[4*(N-1-i) +: 4] == 4'd0)) begin
                blank_mask[i] = 1'b1;
            end else begin
                lead = 1'b0;
            end
        end
    end

    always_comb begin
        pos       = int'(idx_q);
        dig       = 0;
        nyb       = 4'h0;
        nyb_blank = 1'b0;
        cur_byte  = 8'h0A;
        if (pos == L - 2) begin
            cur_byte = 8'h0D;
        end else if (pos < L - 2) begin
            if ((HAS_DP != 0) && (pos == N - DP)) begin
                cur_byte = 8'h2E;
            end else begin
                dig = ((HAS_DP != 0) && (pos > N - DP)) ? pos - 1 : pos;
                for (int i = 0; i < N; i++) begin
                    if (i == dig) begin
                        nyb       = line_q[4*(N-1-i) +: 4];
                        nyb_blank = mask_q[i];
                    end
                end
                if (nyb_blank) begin
                    cur_byte = 8'h20;
                end else if (nyb > 4'd9) begin
                    cur_byte = 8'h3F;
                end else begin
                    cur_byte = 8'h30 + {4'h0, nyb};
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        line_d      = line_q;
        pend_d      = pend_q;
        pend_vld_d  = pend_vld_q;
        ovr_d       = ovr_q;
        idx_d       = idx_q;
        mask_d      = mask_q;
        dat_d       = dat_q;
        uart_wr     = 1'b0;
        line_active = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bcd_valid) begin
                    line_d  = bcd_in;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                line_active = 1'b1;
                idx_d       = '0;
                mask_d      = blank_mask;
                state_d     = S_ISSUE;
            end
            S_ISSUE: begin
                line_active = 1'b1;
                if (!uart_busy) begin
                    uart_wr = 1'b1;
                    dat_d   = cur_byte;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                line_active = 1'b1;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                line_active = 1'b1;
                if (!uart_busy) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + idx_t'(1);
                        state_d = S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                if (bcd_valid || pend_vld_q) begin
                    line_d     = bcd_valid ? bcd_in : pend_q;
                    pend_vld_d = 1'b0;
                    state_d    = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Mid-line results park in the pending slot; a full slot is overwritten by the newer one.
        if (bcd_valid && (state_q inside {S_LOAD, S_ISSUE, S_GAP, S_WAIT})) begin
            pend_d     = bcd_in;
            pend_vld_d = 1'b1;
        end
        if (bcd_valid && pend_vld_q && (ovr_q != 8'hFF)) begin
            ovr_d = ovr_q + 8'd1;
        end
    end

    assign uart_dat      = uart_wr ? cur_byte : dat_q;
    assign overrun_count = ovr_q;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q    <= S_IDLE;
            line_q     <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            ovr_q      <= 8'h00;
            idx_q      <= '0;
            mask_q     <= '0;
            dat_q      <= 8'h00;
        end else begin
            state_q    <= state_d;
            line_q     <= line_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            ovr_q      <= ovr_d;
            idx_q      <= idx_d;
            mask_q     <= mask_d;
            dat_q      <= dat_d;
        end
    end

endmodule

// File: tb/tb_frequency_uart_reporter.sv
// Three reporter configurations (blanked, unblanked, two decimals) against a string-building reference model.
module tb_frequency_uart_reporter;

    logic        clock = 1'b0;
    logic        resetb;
    logic [31:0] bcd_in;
    logic [2:0]  vld;
    logic        wr   [3];
    logic [7:0]  dat  [3];
    logic        busy [3];
    logic        la   [3];
    logic [7:0]  ovr  [3];
    int          cnt  [3];
    logic        prev_wr [3];
    logic [7:0]  got_q [3][$];
    logic [7:0]  exp_q [3][$];
    bit          rand_busy;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          viol     = 0;

    always #5 clock = ~clock;

    frequency_uart_reporter #(.NUMBER_OF_DIGITS(8), .BLANK_LEADING_ZEROS(1), .DECIMAL_POINT_POSITION(0)) u0 (
        .clock(clock), .resetb(resetb), .bcd_in(bcd_in), .bcd_valid(vld[0]), .uart_busy(busy[0]),
        .uart_wr(wr[0]), .uart_dat(dat[0]), .line_active(la[0]), .overrun_count(ovr[0]));
    frequency_uart_reporter #(.NUMBER_OF_DIGITS(8), .BLANK_LEADING_ZEROS(0), .DECIMAL_POINT_POSITION(0)) u1 (
        .clock(clock), .resetb(resetb), .bcd_in(bcd_in), .bcd_valid(vld[1]), .uart_busy(busy[1]),
        .uart_wr(wr[1]), .uart_dat(dat[1]), .line_active(la[1]), .overrun_count(ovr[1]));
    frequency_uart_reporter #(.NUMBER_OF_DIGITS(8), .BLANK_LEADING_ZEROS(1), .DECIMAL_POINT_POSITION(2)) u2 (
        .clock(clock), .resetb(resetb), .bcd_in(bcd_in), .bcd_valid(vld[2]), .uart_busy(busy[2]),
        .uart_wr(wr[2]), .uart_dat(dat[2]), .line_active(la[2]), .overrun_count(ovr[2]));

    // Transmitter model: busy from the cycle after a write for a fixed or random byte time.
    always @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            for (int k = 0; k < 3; k++) cnt[k] <= 0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (wr[k]) cnt[k] <= rand_busy ? int'($urandom_range(1, 12)) : 10;
                else if (cnt[k] != 0) cnt[k] <= cnt[k] - 1;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 3; k++) busy[k] = (cnt[k] != 0);
    end

    always @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            for (int k = 0; k < 3; k++) prev_wr[k] <= 1'b0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (wr[k]) got_q[k].push_back(dat[k]);
                if (wr[k] && (prev_wr[k] || busy[k])) viol++;
                prev_wr[k] <= wr[k];
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_checks++;
        if (obs !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, req);
        end
    endtask

    // Reference: one character per digit, leading zeros blanked until the first nonzero
    // digit or the digit left of the point, '.' before the last dp digits, then CR LF.
    task automatic build_exp(input int k, input logic [31:0] v);
        int         blank;
        int         dp;
        bit         seen;
        logic [3:0] d;
        blank = (k == 1) ? 0 : 1;
        dp    = (k == 2) ? 2 : 0;
        seen  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            d = v[28-4*i +: 4];
            if (dp > 0 && i == 8 - dp) exp_q[k].push_back(8'h2E);
            if (d != 4'd0) seen = 1'b1;
            if (blank != 0 && !seen && i < 7 - dp) exp_q[k].push_back(8'h20);
            else if (d > 4'd9)                     exp_q[k].push_back(8'h3F);
            else                                   exp_q[k].push_back(8'h30 + {4'h0, d});
        end
        exp_q[k].push_back(8'h0D);
        exp_q[k].push_back(8'h0A);
    endtask

    task automatic pulse(input logic [2:0] sel, input logic [31:0] v);
        @(negedge clock);
        bcd_in = v;
        vld    = sel;
        @(negedge clock);
        vld    = 3'b000;
    endtask

    task automatic wait_lines(input logic [2:0] sel);
        int cyc;
        bit done;
        int n;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 5000) begin
            @(negedge clock);
            cyc++;
            done = 1'b1;
            for (int k = 0; k < 3; k++)
                if (sel[k] && (got_q[k].size() < exp_q[k].size() || la[k])) done = 1'b0;
        end
        check_eq("line_done_in_budget", {31'd0, done}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            if (sel[k]) begin
                check_eq($sformatf("line_len_inst%0d", k), got_q[k].size(), exp_q[k].size());
                n = (got_q[k].size() < exp_q[k].size()) ? got_q[k].size() : exp_q[k].size();
                for (int i = 0; i < n; i++)
                    check_eq($sformatf("byte%0d_inst%0d", i, k), {24'd0, got_q[k][i]}, {24'd0, exp_q[k][i]});
                got_q[k].delete();
                exp_q[k].delete();
            end
        end
    endtask

    task automatic run_all(input logic [31:0] v);
        for (int k = 0; k < 3; k++) build_exp(k, v);
        pulse(3'b111, v);
        wait_lines(3'b111);
    endtask

    initial begin
        logic [31:0] v;
        int          lat;
        int          nlead;
        int          d;
        resetb    = 1'b0;
        vld       = 3'b000;
        bcd_in    = 32'h0;
        rand_busy = 1'b0;
        repeat (2) @(negedge clock);
        for (int k = 0; k < 3; k++) begin
            check_eq("reset_uart_wr", {31'd0, wr[k]}, 32'd0);
            check_eq("reset_uart_dat", {24'd0, dat[k]}, 32'd0);
            check_eq("reset_line_active", {31'd0, la[k]}, 32'd0);
            check_eq("reset_overrun", {24'd0, ovr[k]}, 32'd0);
        end
        resetb = 1'b1;

        // First line also measures strobe-to-first-write latency.
        for (int k = 0; k < 3; k++) build_exp(k, 32'h00123456);
        @(negedge clock);
        bcd_in = 32'h00123456;
        vld    = 3'b111;
        @(negedge clock);
        vld = 3'b000;
        lat = 1;
        while (!wr[0] && lat < 50) begin
            @(negedge clock);
            lat++;
        end
        check_eq("first_wr_latency", lat, 2);
        wait_lines(3'b111);

        run_all(32'h00000000);
        run_all(32'h00000005);
        run_all(32'h0000A001);

        // A starts a line, B parks, C overwrites B.
        build_exp(0, 32'h00000111);
        build_exp(0, 32'h00000333);
        pulse(3'b001, 32'h00000111);
        repeat (20) @(negedge clock);
        pulse(3'b001, 32'h00000222);
        repeat (20) @(negedge clock);
        pulse(3'b001, 32'h00000333);
        wait_lines(3'b001);
        check_eq("overrun_after_abc", {24'd0, ovr[0]}, 32'd1);

        // Reset after the fourth byte of a line.
        pulse(3'b001, 32'h87654321);
        lat = 0;
        while (got_q[0].size() < 4 && lat < 1000) begin
            @(negedge clock);
            lat++;
        end
        check_eq("reached_fourth_byte", {31'd0, got_q[0].size() >= 4}, 32'd1);
        resetb = 1'b0;
        #1;
        check_eq("midreset_uart_wr", {31'd0, wr[0]}, 32'd0);
        check_eq("midreset_uart_dat", {24'd0, dat[0]}, 32'd0);
        check_eq("midreset_line_active", {31'd0, la[0]}, 32'd0);
        check_eq("midreset_overrun", {24'd0, ovr[0]}, 32'd0);
        repeat (2) @(negedge clock);
        resetb = 1'b1;
        got_q[0].delete();
        exp_q[0].delete();
        build_exp(0, 32'h00000001);
        pulse(3'b001, 32'h00000001);
        wait_lines(3'b001);
        check_eq("overrun_after_reset", {24'd0, ovr[0]}, 32'd0);

        rand_busy = 1'b1;
        for (int t = 0; t < 20; t++) begin
            nlead = $urandom_range(0, 8);
            v     = 32'h0;
            for (int i = 0; i < 8; i++) begin
                if (i < nlead) d = 0;
                else if ($urandom_range(0, 7) == 0) d = $urandom_range(10, 15);
                else d = $urandom_range(0, 9);
                v[28-4*i +: 4] = 4'(d);
            end
            run_all(v);
        end

        check_eq("wr_protocol_violations", viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
